// File: rtl/instruction_encoder_loader.sv
// Encodes symbolic instruction fields into 32-bit MIPS words and streams
// them into instruction memory at sequential word addresses.
module instruction_encoder_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] count,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic [15:0]        in_imm,
  input  logic [25:0]        in_target,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COUNT_W-1:0]  rem_q, rem_d;
  logic                err_q, err_d;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;

  logic                accept;
  logic [31:0]         enc_word;
  logic                enc_valid;

  assign in_ready  = (state_q == S_RUN);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;

  // Field encoder: each format only pulls in the fields it owns.
  always_comb begin
    enc_word  = '0;
    enc_valid = 1'b1;
    case (in_op)
      4'd0:  enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd1:  enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd2:  enc_word = {6'b000010, in_target};
      4'd3:  enc_word = {6'b000000, in_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
      4'd4:  enc_word = {6'b000011, in_target};
      4'd5:  enc_word = {6'b000101, in_rs, in_rt, in_imm};
      4'd6:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd7:  enc_word = {6'b001110, in_rs, in_rt, in_imm};
      4'd8:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      4'd9:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      4'd10: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      4'd11: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101010};
      default: begin
        enc_word  = '0;
        enc_valid = 1'b0;
      end
    endcase
  end

  // Session control: next state, write pointer, remaining count, error flag.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr & ~ADDR_W'(3);
          rem_d   = count;
          err_d   = 1'b0;
          state_d = (count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(4);
          rem_d  = rem_q - COUNT_W'(1);
          if (!enc_valid) err_d = 1'b1;
          if (rem_q == COUNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Memory write port: one registered write per accepted bundle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= accept;
      if (accept) begin
        waddr_q <= addr_q;
        wdata_q <= enc_word;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Scoreboard bench for instruction_encoder_loader: stimulus pushes expected
// memory writes, a negedge monitor pops and compares them.
module tb_instruction_encoder_loader;

  localparam int ADDR_W  = 10;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [COUNT_W-1:0] count;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_op;
  logic [4:0]         in_rs;
  logic [4:0]         in_rt;
  logic [4:0]         in_rd;
  logic [15:0]        in_imm;
  logic [25:0]        in_target;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [31:0]        mem_wdata;
  logic               busy;
  logic               done;
  logic               err;

  instruction_encoder_loader #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb_q[$];
  wr_t exp_e;
  int  compared    = 0;
  int  mismatched  = 0;
  int  done_pulses = 0;

  int f_op[16], f_rs[16], f_rt[16], f_rd[16], f_imm[16], f_tgt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the instruction-set tables, built arithmetically.
  function automatic logic [31:0] ref_word(input longint op, input longint rs, input longint rt,
                                           input longint rd, input longint imm, input longint tgt);
    longint w;
    longint p26, p21, p16;
    p26 = 64'd1 << 26;
    p21 = 64'd1 << 21;
    p16 = 64'd1 << 16;
    case (op)
      0:  w = 35 * p26 + rs * p21 + rt * p16 + imm;
      1:  w = 43 * p26 + rs * p21 + rt * p16 + imm;
      2:  w = 2 * p26 + tgt;
      3:  w = rs * p21 + 8;
      4:  w = 3 * p26 + tgt;
      5:  w = 5 * p26 + rs * p21 + rt * p16 + imm;
      6:  w = 4 * p26 + rs * p21 + rt * p16 + imm;
      7:  w = 14 * p26 + rs * p21 + rt * p16 + imm;
      8:  w = 8 * p26 + rs * p21 + rt * p16 + imm;
      9:  w = rs * p21 + rt * p16 + rd * 2048 + 32;
      10: w = rs * p21 + rt * p16 + rd * 2048 + 34;
      11: w = rs * p21 + rt * p16 + rd * 2048 + 42;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) done_pulses++;
    if (mem_we) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        exp_e = sb_q.pop_front();
        chk("wr_addr", 32'(mem_addr), exp_e.a);
        chk("wr_data", mem_wdata, exp_e.d);
      end
    end
  end

  task automatic set_f(input int i, input int op, input int rs, input int rt,
                       input int rd, input int imm, input int tgt);
    f_op[i] = op; f_rs[i] = rs; f_rt[i] = rt; f_rd[i] = rd; f_imm[i] = imm; f_tgt[i] = tgt;
  endtask

  task automatic rand_f(input int i);
    set_f(i, int'($urandom_range(15)), int'($urandom_range(31)), int'($urandom_range(31)),
          int'($urandom_range(31)), int'($urandom_range(65535)), int'($urandom_range(67108863)));
  endtask

  task automatic drive_f(input int i);
    in_op     = 4'(f_op[i]);
    in_rs     = 5'(f_rs[i]);
    in_rt     = 5'(f_rt[i]);
    in_rd     = 5'(f_rd[i]);
    in_imm    = 16'(f_imm[i]);
    in_target = 26'(f_tgt[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_session(input int base, input int n, input bit gaps);
    int  addr;
    bit  exp_err;
    int  d0;
    int  budget;
    bit  ok;
    addr    = base & 1020;
    exp_err = 1'b0;
    ok      = 1'b1;
    d0      = done_pulses;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    count     = COUNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (n > 0) chk("busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < n && ok; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(2)) begin @(posedge clk); #1; end
      end
      drive_f(i);
      in_valid = 1'b1;
      budget = 0;
      while (!in_ready && budget < 20) begin @(posedge clk); #1; budget++; end
      if (!in_ready) begin
        compared++;
        mismatched++;
        $display("FAIL ready_timeout: got in_ready 0 expected 1 within 20 cycles");
        ok = 1'b0;
      end else begin
        sb_q.push_back('{a: 32'(addr),
                         d: ref_word(f_op[i], f_rs[i], f_rt[i], f_rd[i], f_imm[i], f_tgt[i])});
        if (f_op[i] > 11) exp_err = 1'b1;
        addr = (addr + 4) % 1024;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    if (!ok) begin
      in_valid = 1'b0;
      do_reset();
      sb_q.delete();
      return;
    end
    chk("done_high", 32'(done), 32'd1);
    chk("busy_low", 32'(busy), 32'd0);
    chk("we_in_done", 32'(mem_we), (n > 0) ? 32'd1 : 32'd0);
    chk("err_flag", 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    chk("done_low", 32'(done), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("err_sticky", 32'(err), 32'(exp_err));
    chk("done_once", 32'(done_pulses - d0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // ADDI at 0x040
    set_f(0, 8, 0, 8, 17, 5, 12345);
    run_session(32'h040, 1, 1'b0);

    // ADD then JR back-to-back
    set_f(0, 9, 8, 9, 10, 16'hABCD, 999);
    set_f(1, 3, 31, 7, 5, 16'h1234, 777);
    run_session(32'h100, 2, 1'b0);

    // LW, BEQ, J
    set_f(0, 0, 29, 8, 3, 4, 55);
    set_f(1, 6, 8, 9, 21, 16'hFFFF, 66);
    set_f(2, 2, 4, 5, 6, 16'h7777, 32'h10);
    run_session(32'h204, 3, 1'b0);

    // Address wrap from the top word
    rand_f(0); rand_f(1);
    f_op[0] = 9; f_op[1] = 4;
    run_session((1 << ADDR_W) - 4, 2, 1'b0);

    // Invalid op sets err; next start clears it; count 0 finishes next cycle
    set_f(0, 13, 3, 4, 5, 16'h0F0F, 1234);
    run_session(32'h3A1, 1, 1'b0);
    run_session(32'h010, 0, 1'b0);

    // Reset mid-session with in_valid held
    start = 1'b1; base_addr = 10'h200; count = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    set_f(0, 9, 1, 2, 3, 0, 0);
    drive_f(0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Randomized sessions with random valid gaps
    for (int s = 0; s < 25; s++) begin
      int n;
      n = int'($urandom_range(7));
      for (int i = 0; i < n; i++) rand_f(i);
      run_session(int'($urandom_range(1023)), n, 1'($urandom_range(1)));
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
